// File: rtl/noc_net_iface_if.sv
// Bundle of the core-side and router-side handshake signals of the network
// interface. The slave modport is the view seen by noc_net_iface itself. The
// master modport is the view of the surrounding core/router environment.
interface noc_net_iface_if;
  // core -> NI injection path
  logic [15:0] tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  // NI -> core ejection path
  logic [15:0] rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  // NI -> router local input
  logic [15:0] net_data_o;
  logic        net_enable_o;
  logic        net_credit_i;
  // router local output -> NI
  logic [15:0] net_data_i;
  logic        net_valid_i;
  logic        net_credit_o;
  // sticky status
  logic        rx_ovf_o;
  logic        dest_err_o;

  modport slave (
    input  tx_data_i, tx_valid_i, rx_ready_i, net_credit_i, net_data_i, net_valid_i,
    output tx_ready_o, rx_data_o, rx_valid_o, net_data_o, net_enable_o,
           net_credit_o, rx_ovf_o, dest_err_o
  );

  modport master (
    output tx_data_i, tx_valid_i, rx_ready_i, net_credit_i, net_data_i, net_valid_i,
    input  tx_ready_o, rx_data_o, rx_valid_o, net_data_o, net_enable_o,
           net_credit_o, rx_ovf_o, dest_err_o
  );
endinterface

// File: rtl/noc_net_iface.sv
// NoC network interface: credit-based injection FIFO towards the router local
// input and a first-word-fall-through ejection FIFO towards the core, which
// returns one credit per flit the core consumes.
// Optional feature: define NI_DEST_CHECK_EN to flag received flits whose
// destination field [7:0] does not match {XCOORD, YCOORD}.
module noc_net_iface #(
  parameter int XCOORD   = 0,
  parameter int YCOORD   = 0,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int CREDITS  = 4
) (
  input logic            clk,
  input logic            rst,
  noc_net_iface_if.slave bus
);

  localparam int TX_AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int RX_AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
  localparam logic [3:0]     CREDIT_MAX  = 4'(CREDITS);

  // ---------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------
  logic [15:0]      tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [TX_AW:0]   tx_count_reg, tx_count_next;

  logic [15:0]      rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [RX_AW:0]   rx_count_reg, rx_count_next;

  logic [3:0]       credit_reg, credit_next;
  logic [15:0]      net_data_reg;
  logic             net_enable_reg;
  logic             net_credit_reg;
  logic             rx_ovf_reg;

  // ---------------------------------------------------------------------
  // Injection side control
  // ---------------------------------------------------------------------
  logic        tx_full, tx_empty, tx_push, tx_write, tx_pop;
  logic        credit_ok, credit_inc, send, bypass;
  logic [15:0] send_data;

  assign tx_full  = (tx_count_reg == TX_FULL_CNT);
  assign tx_empty = (tx_count_reg == '0);
  assign tx_push  = bus.tx_valid_i && !tx_full;

  // A credit arriving this cycle is usable immediately, so a stalled head
  // leaves on the cycle right after the router frees a slot.
  assign credit_ok  = (credit_reg != 4'd0) || bus.net_credit_i;
  assign credit_inc = bus.net_credit_i && (credit_reg != CREDIT_MAX);
  assign send       = credit_ok && (!tx_empty || tx_push);

  // An empty FIFO forwards the incoming core flit straight to the output
  // register, giving one cycle from acceptance to net_enable_o.
  assign bypass    = send && tx_empty;
  assign tx_write  = tx_push && !bypass;
  assign tx_pop    = send && !tx_empty;
  assign send_data = tx_empty ? bus.tx_data_i : tx_mem[tx_rd_ptr_reg];

  // ---------------------------------------------------------------------
  // Ejection side control
  // ---------------------------------------------------------------------
  logic rx_full, rx_empty, rx_push, rx_pop, rx_drop;

  assign rx_full  = (rx_count_reg == RX_FULL_CNT);
  assign rx_empty = (rx_count_reg == '0);
  assign rx_pop   = !rx_empty && bus.rx_ready_i;
  // A full FIFO still takes the flit when the head leaves in the same cycle.
  assign rx_push  = bus.net_valid_i && (!rx_full || rx_pop);
  assign rx_drop  = bus.net_valid_i && !rx_push;

  // Next-state for occupancy counters and the credit counter.
  always_comb begin
    tx_count_next = tx_count_reg;
    rx_count_next = rx_count_reg;
    credit_next   = credit_reg;

    case ({tx_write, tx_pop})
      2'b10:   tx_count_next = tx_count_reg + (TX_AW+1)'(1);
      2'b01:   tx_count_next = tx_count_reg - (TX_AW+1)'(1);
      default: tx_count_next = tx_count_reg;
    endcase

    case ({rx_push, rx_pop})
      2'b10:   rx_count_next = rx_count_reg + (RX_AW+1)'(1);
      2'b01:   rx_count_next = rx_count_reg - (RX_AW+1)'(1);
      default: rx_count_next = rx_count_reg;
    endcase

    // Send plus returning credit cancels out; a credit at full count is ignored.
    if (send && !bus.net_credit_i) begin
      credit_next = credit_reg - 4'd1;
    end else if (!send && credit_inc) begin
      credit_next = credit_reg + 4'd1;
    end
  end

  // Control registers: pointers, counters, output strobes and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_reg  <= '0;
      tx_rd_ptr_reg  <= '0;
      tx_count_reg   <= '0;
      rx_wr_ptr_reg  <= '0;
      rx_rd_ptr_reg  <= '0;
      rx_count_reg   <= '0;
      credit_reg     <= CREDIT_MAX;
      net_data_reg   <= '0;
      net_enable_reg <= 1'b0;
      net_credit_reg <= 1'b0;
      rx_ovf_reg     <= 1'b0;
    end else begin
      if (tx_write) tx_wr_ptr_reg <= tx_wr_ptr_reg + TX_AW'(1);
      if (tx_pop)   tx_rd_ptr_reg <= tx_rd_ptr_reg + TX_AW'(1);
      if (rx_push)  rx_wr_ptr_reg <= rx_wr_ptr_reg + RX_AW'(1);
      if (rx_pop)   rx_rd_ptr_reg <= rx_rd_ptr_reg + RX_AW'(1);
      tx_count_reg   <= tx_count_next;
      rx_count_reg   <= rx_count_next;
      credit_reg     <= credit_next;
      net_enable_reg <= send;
      if (send) net_data_reg <= send_data;
      net_credit_reg <= rx_pop;
      if (rx_drop) rx_ovf_reg <= 1'b1;
    end
  end

  // Injection FIFO storage write port.
  always_ff @(posedge clk) begin
    if (tx_write) tx_mem[tx_wr_ptr_reg] <= bus.tx_data_i;
  end

  // Ejection FIFO storage write port.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= bus.net_data_i;
  end

  // ---------------------------------------------------------------------
  // Destination check
  // ---------------------------------------------------------------------
`ifdef NI_DEST_CHECK_EN
  logic dest_err_reg;
  logic dest_mismatch;

  assign dest_mismatch = (bus.net_data_i[7:4] != 4'(XCOORD)) ||
                         (bus.net_data_i[3:0] != 4'(YCOORD));

  // Sticky flag: set by any written flit addressed to another node.
  always_ff @(posedge clk) begin
    if (rst) begin
      dest_err_reg <= 1'b0;
    end else if (rx_push && dest_mismatch) begin
      dest_err_reg <= 1'b1;
    end
  end

  assign bus.dest_err_o = !rst && dest_err_reg;
`else
  // Coordinates have no consumer without the check; keep them referenced.
  logic [7:0] unused_node_id;
  assign unused_node_id = {4'(XCOORD), 4'(YCOORD)};
  assign bus.dest_err_o = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Outputs: all forced low while reset is held.
  // ---------------------------------------------------------------------
  assign bus.tx_ready_o   = !rst && !tx_full;
  assign bus.rx_valid_o   = !rst && !rx_empty;
  assign bus.rx_data_o    = rst ? 16'h0000 : rx_mem[rx_rd_ptr_reg];
  assign bus.net_data_o   = rst ? 16'h0000 : net_data_reg;
  assign bus.net_enable_o = !rst && net_enable_reg;
  assign bus.net_credit_o = !rst && net_credit_reg;
  assign bus.rx_ovf_o     = !rst && rx_ovf_reg;

endmodule

// File: tb/tb_noc_net_iface.sv
// Self-checking bench for noc_net_iface: directed stimulus feeds expected
// flits into scoreboard queues; a negedge monitor pops and compares every
// net send, every core-side RX pop and every returned credit pulse.
module tb_noc_net_iface;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_net_iface_if bus ();

  noc_net_iface #(
    .XCOORD(1), .YCOORD(2), .TX_DEPTH(4), .RX_DEPTH(4), .CREDITS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int sent_cnt = 0, rx_cnt = 0, credit_cnt = 0;
  logic credit_due = 1'b0;
  logic [15:0] exp_net[$];
  logic [15:0] exp_rx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every DUT-presented output event against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        credit_due = 1'b0;
      end else begin
        if (credit_due || bus.net_credit_o)
          check("net_credit_o_lag", 32'(bus.net_credit_o), 32'(credit_due));
        if (bus.net_credit_o) credit_cnt++;
        credit_due = bus.rx_valid_o && bus.rx_ready_i;
        if (bus.net_enable_o) begin
          sent_cnt++;
          $display("[TB] net send 0x%04h", bus.net_data_o);
          if (exp_net.size() == 0) check("net_unexpected_send", 32'(bus.net_data_o), 32'hFFFF_FFFF);
          else check("net_data_o", 32'(bus.net_data_o), 32'(exp_net.pop_front()));
        end
        if (bus.rx_valid_o && bus.rx_ready_i) begin
          rx_cnt++;
          $display("[TB] rx pop 0x%04h", bus.rx_data_o);
          if (exp_rx.size() == 0) check("rx_unexpected_pop", 32'(bus.rx_data_o), 32'hFFFF_FFFF);
          else check("rx_data_o", 32'(bus.rx_data_o), 32'(exp_rx.pop_front()));
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.tx_valid_i   = 1'b0;
    bus.net_credit_i = 1'b0;
    bus.net_valid_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    exp_net.delete();
    exp_rx.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  // One core push per cycle; tx_ready_o must be high for it to be accepted.
  task automatic push_tx(input logic [15:0] d);
    bus.tx_data_i  = d;
    bus.tx_valid_i = 1'b1;
    exp_net.push_back(d);
    @(negedge clk);
    check("tx_ready_on_push", 32'(bus.tx_ready_o), 32'd1);
    step();
    bus.tx_valid_i = 1'b0;
  endtask

  // One router flit per cycle into the ejection FIFO.
  task automatic push_rx(input logic [15:0] d, input logic expect_kept);
    bus.net_data_i  = d;
    bus.net_valid_i = 1'b1;
    if (expect_kept) exp_rx.push_back(d);
    step();
    bus.net_valid_i = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {26'd0, bus.tx_ready_o, bus.rx_valid_o, bus.net_enable_o,
                 bus.net_credit_o, bus.rx_ovf_o, bus.dest_err_o}, 32'd0);
    check({name, "_data"}, {bus.net_data_o, bus.rx_data_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, c0, r0;
    bus.tx_data_i = '0; bus.net_data_i = '0; bus.rx_ready_i = 1'b0;
    idle_inputs();

    // ---- reset state and single-flit latency ----
    step();
    @(negedge clk);
    check_all_zero("reset_outputs");
    step();
    rst = 1'b0;
    @(negedge clk);
    check("tx_ready_after_reset", 32'(bus.tx_ready_o), 32'd1);
    step();
    bus.tx_data_i = 16'h0011; bus.tx_valid_i = 1'b1; exp_net.push_back(16'h0011);
    step();
    bus.tx_valid_i = 1'b0;
    @(negedge clk);
    check("first_send_enable", 32'(bus.net_enable_o), 32'd1);
    check("first_send_data", 32'(bus.net_data_o), 32'h0011);
    s0 = sent_cnt;
    step();
    for (int i = 0; i < 4; i++) push_tx(16'h0101 + 16'(i));
    repeat (4) step();
    check("credits_left_3", 32'(sent_cnt - s0), 32'd3);
    check("net_data_held", 32'(bus.net_data_o), 32'h0103);

    // ---- credit exhaustion, TX backlog, credit release, TX full ----
    do_reset();
    s0 = sent_cnt;
    for (int i = 0; i < 6; i++) push_tx(16'h0200 + 16'(i));
    repeat (3) step();
    check("sent_with_4_credits", 32'(sent_cnt - s0), 32'd4);
    check("tx_ready_holding_2", 32'(bus.tx_ready_o), 32'd1);
    bus.net_credit_i = 1'b1;
    step();
    bus.net_credit_i = 1'b0;
    @(negedge clk);
    check("fifth_send_enable", 32'(bus.net_enable_o), 32'd1);
    check("fifth_send_data", 32'(bus.net_data_o), 32'h0204);
    step();
    step();
    check("sent_after_credit", 32'(sent_cnt - s0), 32'd5);
    for (int i = 0; i < 3; i++) push_tx(16'h0210 + 16'(i));
    @(negedge clk);
    check("tx_ready_when_full", 32'(bus.tx_ready_o), 32'd0);
    check("no_send_at_zero_credit", 32'(sent_cnt - s0), 32'd5);

    // ---- send + credit same cycle at 2, saturation at 4 ----
    do_reset();
    s0 = sent_cnt;
    push_tx(16'h0300);
    push_tx(16'h0301);
    bus.net_credit_i = 1'b1;
    push_tx(16'h0302);
    bus.net_credit_i = 1'b0;
    for (int i = 0; i < 3; i++) push_tx(16'h0303 + 16'(i));
    repeat (3) step();
    check("credits_stay_2", 32'(sent_cnt - s0), 32'd5);
    do_reset();
    bus.net_credit_i = 1'b1;
    step();
    bus.net_credit_i = 1'b0;
    s0 = sent_cnt;
    for (int i = 0; i < 6; i++) push_tx(16'h0400 + 16'(i));
    repeat (3) step();
    check("credits_saturate_4", 32'(sent_cnt - s0), 32'd4);

    // ---- RX overflow and credit return ----
    do_reset();
    bus.rx_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_rx(16'hA001 + 16'(i), 1'b1);
    bus.net_data_i = 16'hA005; bus.net_valid_i = 1'b1;
    @(negedge clk);
    check("rx_ovf_before_drop", 32'(bus.rx_ovf_o), 32'd0);
    step();
    bus.net_valid_i = 1'b0;
    @(negedge clk);
    check("rx_ovf_set", 32'(bus.rx_ovf_o), 32'd1);
    check("rx_head_kept", 32'(bus.rx_data_o), 32'hA001);
    step();
    c0 = credit_cnt; r0 = rx_cnt;
    bus.rx_ready_i = 1'b1;
    repeat (4) step();
    bus.rx_ready_i = 1'b0;
    repeat (2) step();
    check("rx_pops", 32'(rx_cnt - r0), 32'd4);
    check("credit_pulses", 32'(credit_cnt - c0), 32'd4);
    check("rx_empty_after_drain", 32'(bus.rx_valid_o), 32'd0);
    // write + pop at full both succeed
    for (int i = 0; i < 4; i++) push_rx(16'hB001 + 16'(i), 1'b1);
    r0 = rx_cnt;
    bus.rx_ready_i = 1'b1;
    push_rx(16'hB005, 1'b1);
    repeat (5) step();
    bus.rx_ready_i = 1'b0;
    step();
    check("rx_full_write_pop", 32'(rx_cnt - r0), 32'd5);
    check("rx_scoreboard_drained", 32'(exp_rx.size()), 32'd0);
    check("rx_ovf_sticky", 32'(bus.rx_ovf_o), 32'd1);

    // ---- destination check ----
    do_reset();
    bus.rx_ready_i = 1'b1;
    push_rx(16'h0012, 1'b1);
    step();
    check("dest_ok_no_err", 32'(bus.dest_err_o), 32'd0);
    push_rx(16'h0013, 1'b1);
    step();
`ifdef NI_DEST_CHECK_EN
    check("dest_err_set", 32'(bus.dest_err_o), 32'd1);
    push_rx(16'h0012, 1'b1);
    repeat (2) step();
    check("dest_err_sticky", 32'(bus.dest_err_o), 32'd1);
`else
    check("dest_err_disabled", 32'(bus.dest_err_o), 32'd0);
`endif
    check("misrouted_delivered", 32'(exp_rx.size()), 32'd0);
    bus.rx_ready_i = 1'b0;
    do_reset();
    check("dest_err_cleared", 32'(bus.dest_err_o), 32'd0);

    // ---- reset mid-traffic ----
    for (int i = 0; i < 7; i++) push_tx(16'h0500 + 16'(i));
    push_rx(16'h0601, 1'b1);
    push_rx(16'h0602, 1'b1);
    step();
    rst = 1'b1;
    bus.rx_ready_i = 1'b1;
    exp_net.delete();
    exp_rx.delete();
    @(negedge clk);
    check_all_zero("mid_reset_outputs");
    step();
    rst = 1'b0;
    bus.rx_ready_i = 1'b0;
    s0 = sent_cnt; c0 = credit_cnt;
    @(negedge clk);
    check("post_reset_tx_ready", 32'(bus.tx_ready_o), 32'd1);
    check("post_reset_strobes", {30'd0, bus.net_enable_o, bus.net_credit_o}, 32'd0);
    check("post_reset_rx_valid", 32'(bus.rx_valid_o), 32'd0);
    repeat (3) step();
    check("no_stale_sends", 32'(sent_cnt - s0), 32'd0);
    check("no_stale_credits", 32'(credit_cnt - c0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_net_iface.md
NOC_NET_IFACE -- requirements
Module: noc_net_iface

Interface
REQ-001 SHALL have parameter XCOORD, default 0: 4-bit X coordinate of this node; checked against flit bits [7:4].
REQ-002 SHALL have parameter YCOORD, default 0: 4-bit Y coordinate of this node; checked against flit bits [3:0].
REQ-003 SHALL have parameter TX_DEPTH, default 4: injection FIFO entries (power of 2, 2..16).
REQ-004 SHALL have parameter RX_DEPTH, default 4: ejection FIFO entries (power of 2, 2..16).
REQ-005 SHALL have parameter CREDITS, default 4: downstream router local input buffer depth (1..15).
REQ-006 SHALL have clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have tx_data_i, input, 16 bits: core flit to inject.
REQ-009 SHALL have tx_valid_i, input, 1 bit: core flit valid.
REQ-010 SHALL have tx_ready_o, output, 1 bit: injection FIFO can accept a flit.
REQ-011 SHALL have rx_data_o, output, 16 bits: ejected flit to core.
REQ-012 SHALL have rx_valid_o, output, 1 bit: rx_data_o valid.
REQ-013 SHALL have rx_ready_i, input, 1 bit: core accepts rx_data_o.
REQ-014 SHALL have net_data_o, output, 16 bits: flit to router local input.
REQ-015 SHALL have net_enable_o, output, 1 bit: net_data_o valid; one-cycle strobe per flit.
REQ-016 SHALL have net_credit_i, input, 1 bit: one-cycle strobe, router freed one local input slot.
REQ-017 SHALL have net_data_i, input, 16 bits: flit from router local output.
REQ-018 SHALL have net_valid_i, input, 1 bit: net_data_i valid.
REQ-019 SHALL have net_credit_o, output, 1 bit: one-cycle strobe returning one credit to the router.
REQ-020 SHALL have rx_ovf_o, output, 1 bit: sticky; an ejection write was dropped.
REQ-021 SHALL have dest_err_o, output, 1 bit: sticky; a misrouted flit was received (REQ-035).

Function
REQ-022 SHALL accept a core flit in every cycle with tx_valid_i=1 and tx_ready_o=1.
REQ-023 SHALL drive tx_ready_o=1 when TX occupancy < TX_DEPTH; a same-cycle pop SHALL NOT raise tx_ready_o while full.
REQ-024 SHALL keep a credit counter, range 0..CREDITS.
REQ-025 SHALL send when TX is non-empty and credits > 0: pop head, register it to net_data_o, pulse net_enable_o next cycle, decrement credits.
REQ-026 SHALL send at most one flit per cycle, in FIFO order.
REQ-027 SHALL give 1-cycle latency: a flit accepted at cycle N into an empty FIFO with credits > 0 appears on net at N+1.
REQ-028 SHALL hold net_data_o at the last sent value while net_enable_o=0.
REQ-029 SHALL increment credits on net_credit_i; a send plus credit in the same cycle leaves the count unchanged.
REQ-030 SHALL ignore net_credit_i at credits=CREDITS (saturate; no wrap).
REQ-031 SHALL issue no send and hold the TX head while credits=0.
REQ-032 SHALL write net_data_i to the RX FIFO when net_valid_i=1; when RX is full and no pop occurs that cycle, drop the flit and set rx_ovf_o.
REQ-033 SHALL make RX first-word-fall-through: rx_valid_o=non-empty, rx_data_o=head; pop on rx_valid_o and rx_ready_i; simultaneous write and pop at full SHALL succeed.
REQ-034 SHALL pulse net_credit_o for one cycle, registered, in the cycle after each RX pop; back-to-back pops give back-to-back pulses.
REQ-035 SHALL hold rx_ovf_o and dest_err_o until reset once set.

Reset
REQ-036 SHALL, while rst=1, clear both FIFOs, load credits=CREDITS, and drive 0 on tx_ready_o, rx_valid_o, rx_data_o, net_data_o, net_enable_o, net_credit_o, rx_ovf_o and dest_err_o.
REQ-037 SHALL drive tx_ready_o=1 in the first cycle after rst deasserts.
REQ-038 SHALL, on reset mid-traffic, discard in-flight flits and pending credit pulses, and issue no strobes in the cycle after reset.

Configuration
REQ-039 SHALL, with NI_DEST_CHECK_EN defined, set dest_err_o when an RX-written flit has [7:4]!=XCOORD or [3:0]!=YCOORD; the flit SHALL still be delivered.
REQ-040 SHALL, without NI_DEST_CHECK_EN, tie dest_err_o to 0 and omit the comparators.

Verification
REQ-041 SHALL check: reset, then push 0x0011 at cycle 0 -> net_enable_o=1 and net_data_o=0x0011 at cycle 1; credits=3.
REQ-042 SHALL check: push 6 flits with no net_credit_i -> exactly 4 sent; tx_ready_o stays 1 while occupancy < 4 (TX holds 2); one net_credit_i -> the 5th flit is sent the next cycle.
REQ-043 SHALL check: net_credit_i and a send in the same cycle at credits=2 -> credits stay 2; net_credit_i at credits=4 -> credits stay 4.
REQ-044 SHALL check: 5 net_valid_i flits with rx_ready_i=0 -> 4 held, rx_ovf_o=1; then rx_ready_i=1 for 4 cycles -> 4 net_credit_o pulses, each lagging its pop by 1 cycle.
REQ-045 SHALL check, with NI_DEST_CHECK_EN and XCOORD=1, YCOORD=2: receive 0x0012 -> dest_err_o stays 0; receive 0x0013 -> dest_err_o=1, flit delivered, sticky until rst.
REQ-046 SHALL check: assert rst with 3 flits in TX and 2 in RX -> all outputs 0 next cycle, tx_ready_o=1 after release, no stale net_credit_o.
